// File: rtl/ones_zeros_pattern_gen.sv
// Pattern source for the ones/zeros detectors: emits num_words words of the
// selected pattern over valid/ready. Each word carries its expected flags.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, mode       launch request and pattern select (sampled in IDLE)
//   num_words         run length in words
//   data_out, valid   word stream, held stable while ready is low
//   ready             downstream accept
//   expect_ones/zeros expected detector flags for data_out
//   busy, done        run in progress / one-cycle end-of-run pulse
module ones_zeros_pattern_gen #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [COUNT_W-1:0] num_words,
  output logic [WIDTH-1:0]   data_out,
  output logic               valid,
  input  logic               ready,
  output logic               expect_ones,
  output logic               expect_zeros,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state, n_state;
  logic [1:0]         mode_q, n_mode;
  logic [COUNT_W-1:0] count, n_count;
  logic [WIDTH-1:0]   n_data;
  logic               n_valid;
  logic               n_ones;
  logic               n_zeros;
  logic               n_busy;
  logic               n_done;

  function automatic logic [WIDTH-1:0] first_word(input logic [1:0] m);
    logic [WIDTH-1:0] w;
    unique case (m)
      2'd1:    w = '0;
      2'd3:    w = WIDTH'(1);
      default: w = '1;
    endcase
    return w;
  endfunction

  function automatic logic [WIDTH-1:0] next_word(
    input logic [1:0]       m,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH-1:0] w;
    unique case (m)
      2'd0:    w = '1;
      2'd1:    w = '0;
      2'd2:    w = ~d;
      default: w = {d[WIDTH-2:0], d[WIDTH-1]};
    endcase
    return w;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mode_q       <= '0;
      count        <= '0;
      data_out     <= '0;
      valid        <= 1'b0;
      expect_ones  <= 1'b0;
      expect_zeros <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= n_state;
      mode_q       <= n_mode;
      count        <= n_count;
      data_out     <= n_data;
      valid        <= n_valid;
      expect_ones  <= n_ones;
      expect_zeros <= n_zeros;
      busy         <= n_busy;
      done         <= n_done;
    end
  end

  always_comb begin
    n_state = state;
    n_mode  = mode_q;
    n_count = count;
    n_data  = data_out;
    n_valid = valid;
    n_ones  = expect_ones;
    n_zeros = expect_zeros;
    n_busy  = busy;
    n_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (num_words != '0) begin
            n_state = RUN;
            n_mode  = mode;
            n_count = num_words;
            n_data  = first_word(mode);
            n_valid = 1'b1;
            n_busy  = 1'b1;
          end else begin
            n_state = DONE;
            n_done  = 1'b1;
          end
        end
      end
      RUN: begin
        if (valid && ready) begin
          if (count == COUNT_W'(1)) begin
            n_state = DONE;
            n_valid = 1'b0;
            n_busy  = 1'b0;
            n_done  = 1'b1;
          end else begin
            n_count = count - COUNT_W'(1);
            n_data  = next_word(mode_q, data_out);
          end
        end
      end
      DONE: begin
        n_state = IDLE;
      end
      default: begin
        n_state = IDLE;
        n_valid = 1'b0;
        n_busy  = 1'b0;
      end
    endcase
    // Flags always track the word being registered alongside them.
    n_ones  = &n_data;
    n_zeros = ~|n_data;
  end

endmodule

// File: tb/tb_ones_zeros_pattern_gen.sv
// Scoreboard bench for ones_zeros_pattern_gen: directed runs push expected
// words; a negedge monitor compares every presented word against the queue.
module tb_ones_zeros_pattern_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] num_words = 8'd0;
  logic [7:0] data_out;
  logic       valid;
  logic       ready = 1'b0;
  logic       expect_ones;
  logic       expect_zeros;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  logic [7:0] sb[$];

  logic [7:0] v1[3]  = '{8'hFF, 8'hFF, 8'hFF};
  logic [7:0] v2[10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                         8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
  logic [7:0] v3[4]  = '{8'hFF, 8'h00, 8'hFF, 8'h00};
  logic [7:0] v5[5]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] v6[4]  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};

  ones_zeros_pattern_gen #(.WIDTH(8), .COUNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .mode(mode),
    .num_words(num_words),
    .data_out(data_out),
    .valid(valid),
    .ready(ready),
    .expect_ones(expect_ones),
    .expect_zeros(expect_zeros),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", 32'(data_out), 32'hFFFF_FFFF);
      end else begin
        chk("data", 32'(data_out), 32'(sb[0]));
        chk("exp_ones", 32'(expect_ones), 32'(&sb[0]));
        chk("exp_zeros", 32'(expect_zeros), 32'(~|sb[0]));
        if (ready) begin
          void'(sb.pop_front());
          xfers++;
        end
      end
    end
  end

  // Runs one transaction. ready is held low for the first `stall` valid
  // cycles; start is re-pulsed at cycle `pulse_at` (-1: never).
  task automatic run(input logic [1:0] m, input int n, input int stall,
                     input int pulse_at);
    int c;
    xfers = 0;
    mode = m;
    num_words = 8'(n);
    ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode = ~m;
    num_words = 8'hAA;
    c = 0;
    if (n > 0) chk("busy_first", 32'(busy), 32'd1);
    while (!done && c < 200) begin
      ready = (c >= stall);
      start = (c == pulse_at);
      tick();
      c++;
    end
    start = 1'b0;
    if (c >= 200) chk("done_timeout", 32'(c), 32'(stall + n));
    chk("done_cycle", 32'(c), 32'(stall + n));
    chk("xfers", 32'(xfers), 32'(n));
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("valid_at_done", 32'(valid), 32'd0);
    chk("busy_at_done", 32'(busy), 32'd0);
    tick();
    chk("done_width", 32'(done), 32'd0);
    ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_ones", 32'(expect_ones), 32'd0);
    chk("rst_zeros", 32'(expect_zeros), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    foreach (v1[i]) sb.push_back(v1[i]);
    run(2'd0, 3, 0, -1);

    foreach (v2[i]) sb.push_back(v2[i]);
    run(2'd3, 10, 0, -1);

    foreach (v3[i]) sb.push_back(v3[i]);
    run(2'd2, 4, 2, -1);

    run(2'd1, 0, 0, -1);

    foreach (v5[i]) sb.push_back(v5[i]);
    mode = 2'd1;
    num_words = 8'd5;
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("t5_valid", 32'(valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_xfers", 32'(xfers), 32'd2);
    rst = 1'b0;
    sb.delete();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_done", 32'(done), 32'd0);
    end
    sb.push_back(8'h00);
    sb.push_back(8'h00);
    run(2'd1, 2, 0, -1);

    foreach (v6[i]) sb.push_back(v6[i]);
    run(2'd0, 4, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
